// File: rtl/priority_latch_encoder.sv
// priority_latch_encoder: latches request pulses and presents one pending index at a time
// under a valid/ack handshake, with fixed priority and per-bit masking of selection.
module priority_latch_encoder #(
    parameter int N          = 8,
    parameter bit HIGH_FIRST = 1'b1,
    localparam int W         = $clog2(N)
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic [N-1:0] a,
    input  logic [N-1:0] mask,
    input  logic         ack,
    output logic [W-1:0] y,
    output logic         valid,
    output logic [W:0]   count
);
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [W-1:0]   y_q, y_d;
    logic [W:0]     count_q, count_d;
    logic [N-1:0]   clr, cand;
    logic [W-1:0]   sel;
    logic           take;

    always_comb begin
        clr = '0;
        if (state_q == PRESENT && ack) clr[y_q] = 1'b1;
        pending_d = (pending_q & ~clr) | a;
        cand      = pending_d & ~mask;
        // Later loop iterations overwrite earlier ones, so scan order sets priority.
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (HIGH_FIRST && cand[i]) sel = W'(i);
            if (!HIGH_FIRST && cand[N-1-i]) sel = W'(N-1-i);
        end
        count_d = '0;
        for (int i = 0; i < N; i++) count_d = count_d + (W+1)'(pending_d[i]);
        take    = (state_q == IDLE) || ack;
        state_d = take ? ((|cand) ? PRESENT : IDLE) : state_q;
        y_d     = (take && |cand) ? sel : y_q;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            y_q       <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            y_q       <= y_d;
            count_q   <= count_d;
        end
    end

    assign y     = y_q;
    assign valid = (state_q == PRESENT);
    assign count = count_q;
endmodule

// File: tb/tb_priority_latch_encoder.sv
// tb_priority_latch_encoder: directed scenarios with expected outputs queued at drive time
// and compared after each edge; a second instance covers lowest-index-first priority.
module tb_priority_latch_encoder;
    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic [7:0] a = '0, mask = '0;
    logic       ack = 1'b0;
    logic [2:0] y, y_lo;
    logic       valid, valid_lo;
    logic [3:0] count, count_lo;
    int         n_chk = 0, n_pass = 0, step = 0;

    typedef struct {
        int y, v, c, lo, ly, lv;
    } exp_t;
    exp_t exp_q[$];

    priority_latch_encoder #(.N(8), .HIGH_FIRST(1'b1)) dut (
        .clk(clk), .n_reset(n_reset), .a(a), .mask(mask), .ack(ack),
        .y(y), .valid(valid), .count(count)
    );
    priority_latch_encoder #(.N(8), .HIGH_FIRST(1'b0)) dut_lo (
        .clk(clk), .n_reset(n_reset), .a(a), .mask(mask), .ack(ack),
        .y(y_lo), .valid(valid_lo), .count(count_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s step %0d: got %0d expected %0d", tag, step, got, want);
    endtask

    task automatic cyc(input logic [7:0] ai, input logic [7:0] mi, input logic ak,
                       input int ey, input int ev, input int ec,
                       input int lo = 0, input int ly = 0, input int lv = 0);
        exp_t e;
        a = ai; mask = mi; ack = ak;
        exp_q.push_back('{ey, ev, ec, lo, ly, lv});
        @(posedge clk);
        #1;
        step++;
        e = exp_q.pop_front();
        chk("y", int'(y), e.y);
        chk("valid", int'(valid), e.v);
        chk("count", int'(count), e.c);
        if (e.lo != 0) begin
            chk("lo_y", int'(y_lo), e.ly);
            chk("lo_valid", int'(valid_lo), e.lv);
        end
    endtask

    initial begin
        #12;
        chk("reset_y", int'(y), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_count", int'(count), 0);
        @(negedge clk);
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        // Two requests, highest first (lo instance: lowest first)
        cyc(8'h24, 8'h00, 1'b0, 5, 1, 2, 1, 2, 1);
        cyc(8'h00, 8'h00, 1'b1, 2, 1, 1, 1, 5, 1);
        cyc(8'h00, 8'h00, 1'b1, 2, 0, 0, 1, 5, 0);
        cyc(8'h82, 8'h00, 1'b0, 7, 1, 2, 1, 1, 1);
        cyc(8'h00, 8'h00, 1'b1, 1, 1, 1, 1, 7, 1);
        cyc(8'h00, 8'h00, 1'b1, 1, 0, 0, 1, 7, 0);
        // No preemption while waiting for ack
        cyc(8'h04, 8'h00, 1'b0, 2, 1, 1);
        cyc(8'h80, 8'h00, 1'b0, 2, 1, 2);
        cyc(8'h00, 8'h00, 1'b1, 7, 1, 1);
        cyc(8'h00, 8'h00, 1'b1, 7, 0, 0);
        // Mask excludes selection; masking a presented bit does not retract it
        cyc(8'h48, 8'h40, 1'b0, 3, 1, 2);
        cyc(8'h00, 8'h00, 1'b1, 6, 1, 1);
        cyc(8'h00, 8'h40, 1'b0, 6, 1, 1);
        cyc(8'h00, 8'h40, 1'b1, 6, 0, 0);
        cyc(8'h01, 8'h01, 1'b0, 6, 0, 1);
        cyc(8'h00, 8'h00, 1'b0, 0, 1, 1);
        cyc(8'h00, 8'h00, 1'b1, 0, 0, 0);
        // Set wins over clear
        cyc(8'h10, 8'h00, 1'b0, 4, 1, 1);
        cyc(8'h10, 8'h00, 1'b1, 4, 1, 1);
        cyc(8'h00, 8'h00, 1'b1, 4, 0, 0);
        // Ack ignored in IDLE, including with a masked pending bit
        cyc(8'h00, 8'h00, 1'b1, 4, 0, 0);
        cyc(8'h08, 8'h08, 1'b1, 4, 0, 1);
        cyc(8'h00, 8'h08, 1'b1, 4, 0, 1);
        cyc(8'h00, 8'h00, 1'b0, 3, 1, 1);
        cyc(8'h00, 8'h00, 1'b1, 3, 0, 0);
        // All bits set, then drain down to count 3
        cyc(8'hFF, 8'h00, 1'b0, 7, 1, 8);
        cyc(8'h00, 8'h00, 1'b1, 6, 1, 7);
        cyc(8'h00, 8'h00, 1'b1, 5, 1, 6);
        cyc(8'h00, 8'h00, 1'b1, 4, 1, 5);
        cyc(8'h00, 8'h00, 1'b1, 3, 1, 4);
        cyc(8'h00, 8'h00, 1'b1, 2, 1, 3);
        // Asynchronous reset between edges during PRESENT
        ack = 1'b0;
        #2 n_reset = 1'b0;
        #1;
        chk("async_rst_y", int'(y), 0);
        chk("async_rst_valid", int'(valid), 0);
        chk("async_rst_count", int'(count), 0);
        #1 n_reset = 1'b1;
        cyc(8'h00, 8'h00, 1'b0, 0, 0, 0);
        cyc(8'h00, 8'h00, 1'b0, 0, 0, 0);
        // Request on the first edge after release is latched
        #2 n_reset = 1'b0;
        #1 n_reset = 1'b1;
        cyc(8'h08, 8'h00, 1'b0, 3, 1, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/priority_latch_encoder.md
PRIORITY_LATCH_ENCODER -- requirements
Module: priority_latch_encoder

Interface
REQ-001 SHALL have parameter N, default 8: number of request inputs, legal range 2..32.
REQ-002 SHALL have parameter HIGH_FIRST, default 1: 1 = highest index wins, 0 = lowest index wins.
REQ-003 SHALL have derived localparam W = $clog2(N), which is the width of y.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port n_reset, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port a, input, N bits: request lines, sampled every rising edge (level or single-cycle pulse).
REQ-007 SHALL have port mask, input, N bits: 1 = bit excluded from selection but still latched.
REQ-008 SHALL have port ack, input, 1 bit: consumer accepts the presented y.
REQ-009 SHALL have port y, output, W bits: registered index of the selected request.
REQ-010 SHALL have port valid, output, 1 bit: registered; y holds a pending, unacknowledged request.
REQ-011 SHALL have port count, output, W+1 bits: registered number of set pending bits, masked or unmasked.

Function
REQ-012 SHALL hold an N-bit pending register; at every edge, pending_next = (pending & ~clr) | a, so set wins over clear on the same bit.
REQ-013 SHALL assert clr only for bit y, and only on an edge where valid=1 and ack=1; otherwise clr=0.
REQ-014 SHALL define the candidate set at an edge as (pending_next & ~mask).
REQ-015 SHALL select from the candidate set the highest set index when HIGH_FIRST=1, and the lowest set index when HIGH_FIRST=0.
REQ-016 SHALL implement an FSM with two states: IDLE (valid=0) and PRESENT (valid=1).
REQ-017 In IDLE with an empty candidate set, SHALL stay in IDLE and hold y unchanged.
REQ-018 In IDLE with a non-empty candidate set, SHALL load y with the selection and go to PRESENT at the same edge, giving a latency of one edge from a to valid.
REQ-019 In PRESENT with ack=0, SHALL hold y and valid stable with no preemption, even if a higher-priority request arrives or mask changes.
REQ-020 In PRESENT with ack=1, SHALL re-evaluate the candidate set after the clear at the same edge: if non-empty, load the new y and stay in PRESENT with no bubble; if empty, go to IDLE.
REQ-021 When ack=1 and a[y]=1 on the same edge, bit y SHALL remain pending and SHALL be eligible for immediate re-selection.
REQ-022 SHALL ignore ack in IDLE, with no effect on pending.
REQ-023 SHALL register count as popcount(pending_next) at each edge; with N at maximum and all bits set, count = N, with no overflow in W+1 bits.
REQ-024 SHALL not retract a presented y when its mask bit is set during PRESENT; masking affects only future selections.
REQ-025 SHALL keep outputs registered, with no combinational path from a, mask or ack to y, valid or count.

Reset
REQ-026 While n_reset=0, SHALL asynchronously force pending=0, y=0, valid=0, count=0, and state=IDLE.
REQ-027 Reset asserted mid-PRESENT SHALL discard all pending requests; nothing SHALL be presented after release until a new request arrives.
REQ-028 At the first edge after n_reset is deasserted, SHALL apply normal rules, so requests on a at that edge are latched.

Verification
REQ-029 With N=8 and HIGH_FIRST=1, SHALL pass this scenario: a=8'b0010_0100 for one cycle, mask=0 -> next edge y=5, valid=1, count=2; ack one cycle -> y=2, valid=1, count=1; ack -> valid=0, count=0.
REQ-030 With N=8 and HIGH_FIRST=0, SHALL pass this scenario: a=8'b1000_0010 -> y=1; on ack -> y=7.
REQ-031 SHALL pass this no-preemption scenario: y=2 presented with ack=0, then a[7] pulsed -> y stays 2 and count=2; on ack -> y=7.
REQ-032 SHALL pass this mask scenario: pending bits 3 and 6 with mask=8'h40 -> y=3; clear mask, ack -> y=6.
REQ-033 SHALL pass this set-wins scenario: a[4] held high while ack pulses with y=4 -> y stays 4, valid stays 1, count unchanged.
REQ-034 SHALL pass this reset scenario: n_reset pulsed low between edges during PRESENT with count=3 -> y=0, valid=0, count=0 immediately, without waiting for a clock edge; after release with a=0 -> valid stays 0.
